// File: rtl/ones_count_seq_if.sv
// Valid/ready bundle between a word producer / result consumer (master) and
// the ones_count_seq engine (slave).
interface ones_count_seq_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/ones_count_seq.sv
// Sequential population count: one CHUNK_W-bit slice per cycle through a shared counter.
// Optional macro EARLY_DONE_EN: finish as soon as the remaining upper chunks are all zero.
module ones_count_seq #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    ones_count_seq_if.slave bus,
    output logic            busy
);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int SUM_W  = $clog2(CHUNK_W + 1);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_out_count;
    logic [IDX_W-1:0]  r_idx;
    logic              r_out_valid;

    logic [SUM_W-1:0]  w_chunk_sum;
    logic [CNT_W-1:0]  w_acc_next;
    logic [DATA_W-1:0] w_shift_next;
    logic              w_last;

    function automatic logic [SUM_W-1:0] popcount_chunk(input logic [CHUNK_W-1:0] chunk);
        logic [SUM_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            sum = sum + SUM_W'(chunk[i]);
        end
        return sum;
    endfunction

    assign w_chunk_sum  = popcount_chunk(r_shift[CHUNK_W-1:0]);
    assign w_acc_next   = r_acc + CNT_W'(w_chunk_sum);
    assign w_shift_next = r_shift >> CHUNK_W;

`ifdef EARLY_DONE_EN
    // Nothing left above the chunk being counted, so this edge holds the final sum.
    assign w_last = (w_shift_next == '0);
`else
    assign w_last = (r_idx == IDX_W'(NCHUNK - 1));
`endif

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assigned first so no path through the case leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_shift     <= bus.in_data;
                        r_acc       <= '0;
                        r_idx       <= '0;
                        r_out_count <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_shift <= w_shift_next;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_out_count <= w_acc_next;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    // in_valid is deliberately ignored here; acceptance waits for IDLE.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_count = r_out_count;
    assign busy          = (r_state != S_IDLE);

endmodule
